li_rr_merge: RTL and testbench

//  N-to-1 round-robin merge for valid/stop latency-insensitive links.

---
 rtl/li_pkg.sv | 27 ++
 rtl/li_skid_fifo2.sv | 71 +++++++
 rtl/li_rr_merge.sv | 96 +++++++++
 tb/tb_li_rr_merge.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/li_pkg.sv
// Shared definitions for the latency-insensitive merge slice: reset level,
// a ceiling-log2 helper and a width-parameterised token typedef macro.

`ifndef LI_PKG_SV
`define LI_PKG_SV

// Declares a single-field token struct of the given data width.
`define LI_TOK_TYPEDEF(name, w) typedef struct packed { logic [(w)-1:0] data; } name;

package li_pkg;

    // Level of reset_n that holds the logic in reset.
    localparam logic RST_ACTIVE = 1'b0;

    // Ceiling log2, used for index widths; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/li_skid_fifo2.sv
// Two-entry flow-through FIFO for one upstream link. When empty, the
// incoming token is presented on dout in the same cycle so it can be taken
// straight into the output register; stop is registered and rises when the
// FIFO will hold two tokens after the current edge.

module li_skid_fifo2
    import li_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             not_empty,
    output logic             stop
);

    `LI_TOK_TYPEDEF(tok_t, WIDTH)

    tok_t       head_q;
    tok_t       tail_q;
    logic [1:0] count_q;
    logic [1:0] count_nxt;

    // Occupancy after this edge; push+pop together leaves it unchanged.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and a latch is inferred.
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + 2'd1;
            2'b01:   count_nxt = count_q - 2'd1;
            default: count_nxt = count_q;
        endcase
    end

    // Occupancy and the registered full flag that backpressures upstream.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset_n == RST_ACTIVE) begin
            count_q <= 2'd0;
            stop    <= 1'b0;
        end else begin
            count_q <= count_nxt;
            stop    <= (count_nxt == 2'd2);
        end
    end

    // Token storage; head_q is the oldest entry, tail_q the second.
    always_ff @(posedge clk) begin
        // NOTE: storage is left unreset; count_q alone decides which entries are meaningful.
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_q.data <= din;
                end else begin
                    tail_q.data <= din;
                end
            end
            2'b01:   head_q <= tail_q;
            2'b11:   head_q.data <= din;
            default: ;
        endcase
    end

    assign dout      = (count_q == 2'd0) ? din : head_q.data;
    assign not_empty = (count_q != 2'd0) | push;

endmodule

// File: rtl/li_rr_merge.sv
// N-to-1 round-robin merge for valid/stop latency-insensitive links.
// Each requester feeds a two-entry FIFO; a rotating-priority arbiter picks
// one non-empty FIFO per cycle into a single output register, tagging the
// token with its source index.

module li_rr_merge
    import li_pkg::*;
#(
    parameter  int WIDTH = 6,
    parameter  int N     = 4,
    localparam int IDXW  = clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_stop,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic [IDXW-1:0]    out_src,
    input  logic               out_stop
);

    logic [N-1:0]     push;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [WIDTH-1:0] head [N];
    logic             ld;
    logic             any_req;
    logic [IDXW-1:0]  win_idx;
    logic [IDXW-1:0]  rr_ptr;
    logic [IDXW-1:0]  rr_nxt;

    for (genvar g = 0; g < N; g++) begin : g_in
        assign push[g] = in_valid[g] & ~in_stop[g];

        li_skid_fifo2 #(
            .WIDTH(WIDTH)
        ) u_buf (
            .clk      (clk),
            .reset_n  (reset_n),
            .push     (push[g]),
            .din      (in_data[g*WIDTH +: WIDTH]),
            .pop      (grant[g]),
            .dout     (head[g]),
            .not_empty(req[g]),
            .stop     (in_stop[g])
        );
    end

    // The output register may take a new token when empty or being drained.
    assign ld = ~out_valid | ~out_stop;

    // Rotating-priority scan: walk offsets from farthest to nearest so the
    // first requester at or after rr_ptr is the one left standing.
    always_comb begin
        any_req = 1'b0;
        win_idx = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if (req[(int'(rr_ptr) + off) % N]) begin
                any_req = 1'b1;
                win_idx = IDXW'((int'(rr_ptr) + off) % N);
            end
        end
    end

    // One-hot grant, only when the output register can accept.
    always_comb begin
        grant = '0;
        if (ld && any_req) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign rr_nxt = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + IDXW'(1);

    // Output register and round-robin pointer, both advanced only on a grant.
    always_ff @(posedge clk) begin
        if (reset_n == RST_ACTIVE) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (ld) begin
            if (any_req) begin
                out_valid <= 1'b1;
                out_data  <= head[win_idx];
                out_src   <= win_idx;
                rr_ptr    <= rr_nxt;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_li_rr_merge.sv
// Directed bench for li_rr_merge (N=4, WIDTH=6). Producers emit base+seq
// tokens and hold them until accepted; a per-source queue scoreboard checks
// every token leaving the merge, alongside hand-computed directed checks.

module tb_li_rr_merge;

    localparam int WIDTH = 6;
    localparam int N     = 4;
    localparam int IDXW  = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_stop;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic [IDXW-1:0]    out_src;
    logic               out_stop;

    always #5 clk = ~clk;

    li_rr_merge #(
        .WIDTH(WIDTH),
        .N    (N)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_stop  (in_stop),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_src  (out_src),
        .out_stop (out_stop)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Producer / scoreboard model
    int               seq  [N];
    int               lim  [N];
    int               base [N];
    logic [N-1:0]     en;
    logic [WIDTH-1:0] exp_q [N][$];
    int               src_log [$];
    int               acc_total;
    int               con_total;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_valid[i]                = en[i] && (seq[i] < lim[i]);
            in_data[i*WIDTH +: WIDTH]  = WIDTH'(base[i] + seq[i]);
        end
    endtask

    task automatic tick();
        logic [N-1:0]     acc;
        logic             cons;
        logic [WIDTH-1:0] cd;
        logic [IDXW-1:0]  cs;
        logic             rst_now;
        acc     = in_valid & ~in_stop;
        cons    = out_valid & ~out_stop;
        cd      = out_data;
        cs      = out_src;
        rst_now = !reset_n;
        @(posedge clk);
        #1;
        if (rst_now) begin
            for (int i = 0; i < N; i++) exp_q[i].delete();
            acc_total = 0;
            con_total = 0;
        end else begin
            if (cons) begin
                src_log.push_back(int'(cs));
                con_total++;
                check("sb_has_token", 32'(exp_q[cs].size() > 0), 32'd1);
                if (exp_q[cs].size() > 0) begin
                    check("sb_data", 32'(cd), 32'(exp_q[cs].pop_front()));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    exp_q[i].push_back(WIDTH'(base[i] + seq[i]));
                    seq[i]++;
                    acc_total++;
                end
            end
        end
        drive();
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] sd;
        logic [IDXW-1:0]  ss;
        logic             sv;
        int               guard;
        bit               done;

        acc_total = 0;
        con_total = 0;
        for (int i = 0; i < N; i++) begin
            seq[i]  = 0;
            lim[i]  = 1000;
            base[i] = 0;
        end
        out_stop = 1'b0;
        reset_n  = 1'b0;

        // 1. Reset with all inputs valid
        en = 4'hF;
        drive();
        tick();
        tick();
        check("t1_rst_in_stop", 32'(in_stop), 32'h0);
        check("t1_rst_out_valid", 32'(out_valid), 32'h0);
        check("t1_rst_out_src", 32'(out_src), 32'h0);
        check("t1_rst_out_data", 32'(out_data), 32'h0);
        en = 4'h0;
        drive();
        reset_n = 1'b1;
        tick();
        check("t1_rel_in_stop", 32'(in_stop), 32'h0);
        check("t1_rel_out_valid", 32'(out_valid), 32'h0);
        check("t1_rel_out_src", 32'(out_src), 32'h0);

        // 2. Single stream on input 2: tokens 1..10, one per cycle
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            lim[i] = 0;
        end
        en = 4'b0100;
        base[2] = 1;
        lim[2]  = 10;
        drive();
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("t2_valid", 32'(out_valid), 32'd1);
            check("t2_data", 32'(out_data), 32'(k));
            check("t2_src", 32'(out_src), 32'd2);
            check("t2_in_stop", 32'(in_stop[2]), 32'd0);
        end
        tick();
        check("t2_idle", 32'(out_valid), 32'd0);

        // 3. All inputs valid: round-robin 0,1,2,3,...
        reset_pulse();
        src_log.delete();
        en = 4'hF;
        for (int i = 0; i < N; i++) begin
            base[i] = 10 * i;
            seq[i]  = 0;
            lim[i]  = 8;
        end
        drive();
        guard = 0;
        while (src_log.size() < 32 && guard < 100) begin
            tick();
            guard++;
        end
        check("t3_count", 32'(src_log.size()), 32'd32);
        for (int k = 0; k < src_log.size() && k < 32; k++) begin
            check("t3_src", 32'(src_log[k]), 32'(k % N));
        end

        // 4. Stall 6 cycles with all inputs valid
        for (int i = 0; i < N; i++) lim[i] = 16;
        drive();
        tick();
        tick();
        tick();
        out_stop = 1'b1;
        sd = out_data;
        ss = out_src;
        sv = out_valid;
        check("t4_valid_at_stall", 32'(sv), 32'd1);
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("t4_frozen_data", 32'(out_data), 32'(sd));
            check("t4_frozen_src", 32'(out_src), 32'(ss));
            check("t4_frozen_valid", 32'(out_valid), 32'(sv));
            if (c >= 2) check("t4_in_stop", 32'(in_stop), 32'hF);
        end
        out_stop = 1'b0;
        guard = 0;
        done  = 1'b0;
        while (!done && guard < 200) begin
            tick();
            guard++;
            done = (out_valid == 1'b0) && (in_valid == '0);
        end
        check("t4_drained", 32'(done), 32'd1);
        check("t4_token_count", 32'(con_total), 32'(acc_total));
        check("t4_accepted", 32'(acc_total), 32'(4 * 16));
        for (int i = 0; i < N; i++) check("t4_queue_empty", 32'(exp_q[i].size()), 32'd0);

        // 5. Wrap check: set rr_ptr to 3 via one token on input 2
        en = 4'b0100;
        lim[2] = seq[2] + 1;
        drive();
        tick();
        tick();
        tick();
        src_log.delete();
        en = 4'b1001;
        base[0] = 50;
        base[3] = 20;
        seq[0] = 0;
        seq[3] = 0;
        lim[0] = 3;
        lim[3] = 3;
        drive();
        guard = 0;
        while (src_log.size() < 6 && guard < 50) begin
            tick();
            guard++;
        end
        check("t5_count", 32'(src_log.size()), 32'd6);
        for (int k = 0; k < src_log.size() && k < 6; k++) begin
            check("t5_src", 32'(src_log[k]), (k % 2 == 0) ? 32'd3 : 32'd0);
        end

        // 6. Mid-operation reset with full buffers and a held output
        en = 4'hF;
        for (int i = 0; i < N; i++) begin
            base[i] = 0;
            lim[i]  = seq[i] + 1000;
        end
        out_stop = 1'b1;
        drive();
        for (int c = 0; c < 4; c++) tick();
        check("t6_full_valid", 32'(out_valid), 32'd1);
        check("t6_full_stop", 32'(in_stop), 32'hF);
        en = 4'h0;
        drive();
        reset_pulse();
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_in_stop", 32'(in_stop), 32'h0);
        check("t6_rst_data", 32'(out_data), 32'h0);
        check("t6_rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
        out_stop = 1'b0;
        en = 4'b0010;
        base[1] = 42;
        seq[1]  = 0;
        lim[1]  = 1;
        drive();
        tick();
        check("t6_fresh_valid", 32'(out_valid), 32'd1);
        check("t6_fresh_data", 32'(out_data), 32'd42);
        check("t6_fresh_src", 32'(out_src), 32'd1);
        tick();
        check("t6_no_stale", 32'(out_valid), 32'd0);
        check("t6_token_count", 32'(con_total), 32'(acc_total));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
